// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared types for the hazard controller (fwd_sel_e, stage_info_t, REG_AW defaults, stage write-match helper)
package riscv_pipe_pkg;
  localparam int REG_AW_DEF = 5;
  localparam int REG_AW_MAX = 8;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_e;
  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic [REG_AW_MAX-1:0] rs1;
    logic [REG_AW_MAX-1:0] rs2;
    logic                  regwrite;
    logic                  memread;
  } stage_info_t;
  function automatic logic writes(stage_info_t s, logic [REG_AW_MAX-1:0] r);
    return s.valid & s.regwrite & (s.rd == r);
  endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// fwd_select: one EX operand's forward source; in rs, mem_s, wb_s -> out sel (MEM non-load beats WB, else regfile)
module fwd_select
  import riscv_pipe_pkg::*;
(
  input  logic [REG_AW_MAX-1:0] rs,
  input  stage_info_t           mem_s,
  input  stage_info_t           wb_s,
  output fwd_sel_e              sel
);
  logic unused_bits;
  assign unused_bits = ^{mem_s, wb_s};
  always_comb sel = (writes(mem_s, rs) && !mem_s.memread) ? FWD_MEM : writes(wb_s, rs) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage stall/flush/freeze/forward control; in clk reset id_* ex_branch_taken mem_req mem_ready, out pc_en ifid_en ifid_flush idex_flush pipe_en fwd_a fwd_b mem_timeout; HAZARD_FWD_EN enables forwarding
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_en,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_timeout
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  stage_info_t ex_q, mem_q, wb_q, ex_d, mem_d, wb_d, id_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d, freeze, hazard, unused_bits;
  logic [REG_AW_MAX-1:0] rs1, rs2;
  assign unused_bits = ^{ex_q, mem_q, wb_q};
  always_comb begin
    // unused or invalid sources become x0, which can never match a writer
    rs1 = (id_valid & id_use_rs1) ? REG_AW_MAX'(id_rs1) : '0;
    rs2 = (id_valid & id_use_rs2) ? REG_AW_MAX'(id_rs2) : '0;
    id_s = '{valid: id_valid, rd: REG_AW_MAX'(id_rd), rs1: rs1, rs2: rs2,
             regwrite: id_valid & id_regwrite & (id_rd != '0), memread: id_valid & id_memread};
`ifdef HAZARD_FWD_EN
    hazard = ex_q.memread & (writes(ex_q, rs1) | writes(ex_q, rs2));
`else
    hazard = writes(ex_q, rs1) | writes(ex_q, rs2) | writes(mem_q, rs1) | writes(mem_q, rs2)
           | writes(wb_q, rs1) | writes(wb_q, rs2);
`endif
    freeze = mem_req & ~mem_ready;
    pc_en = ~freeze & (ex_branch_taken | ~hazard);
    ifid_en = pc_en;
    ifid_flush = ~freeze & ex_branch_taken;
    idex_flush = ~freeze & (ex_branch_taken | hazard);
    pipe_en = ~freeze;
    ex_d = ~pipe_en ? ex_q : idex_flush ? stage_info_t'(0) : id_s;
    mem_d = pipe_en ? ex_q : mem_q;
    wb_d = pipe_en ? mem_q : wb_q;
    cnt_d = ~freeze ? '0 : (cnt_q == CW'(MEM_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
    timeout_d = timeout_q | (cnt_d == CW'(MEM_TIMEOUT));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      ex_q <= ex_d;
      mem_q <= mem_d;
      wb_q <= wb_d;
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign mem_timeout = timeout_q;
`ifdef HAZARD_FWD_EN
  fwd_sel_e sel_a, sel_b;
  fwd_select u_fwd_a (.rs(ex_q.rs1), .mem_s(mem_q), .wb_s(wb_q), .sel(sel_a));
  fwd_select u_fwd_b (.rs(ex_q.rs2), .mem_s(mem_q), .wb_s(wb_q), .sel(sel_b));
  assign fwd_a = sel_a;
  assign fwd_b = sel_b;
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors for pipeline_hazard_ctrl; expectations follow HAZARD_FWD_EN
module tb_pipeline_hazard_ctrl;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [31:0] RUN = 32'b11001, FLUSH = 32'b11111, FROZEN = 32'b00000;
  logic clk = 1'b0, reset = 1'b1;
  logic id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, ex_branch_taken, mem_req, mem_ready;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pipe_en(pipe_en),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ctl();
    return 32'({pc_en, ifid_en, ifid_flush, idex_flush, pipe_en});
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
  endtask
  task automatic ins(input int rs1, input int u1, input int rs2, input int u2, input int rd, input int rw, input int mr);
    id_valid = 1'b1; id_rs1 = 5'(rs1); id_use_rs1 = (u1 != 0); id_rs2 = 5'(rs2); id_use_rs2 = (u2 != 0);
    id_rd = 5'(rd); id_regwrite = (rw != 0); id_memread = (mr != 0);
  endtask
  task automatic push(input int rs1, input int u1, input int rs2, input int u2, input int rd, input int rw,
                      input int mr, output int n);
    ins(rs1, u1, rs2, u2, rd, rw, mr);
    n = 0;
    #1;
    while (!pc_en && n < 8) begin
      check("stall_ctl", ctl(), 32'b00011);
      tick();
      #1;
      n++;
    end
    tick();
  endtask
  task automatic drain();
    idle();
    repeat (3) tick();
  endtask
  always @(negedge clk)
    if (!reset && dut.ex_q.valid && dut.mem_q.valid && dut.mem_q.memread && dut.mem_q.regwrite &&
        (dut.mem_q.rd == dut.ex_q.rs1 || dut.mem_q.rd == dut.ex_q.rs2))
      check("illegal_load_fwd", 32'd1, 32'd0);
  initial begin
    int n;
    idle();
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_ctl", ctl(), RUN);
    check("rst_fwd", 32'({fwd_a, fwd_b}), 0);
    check("rst_timeout", 32'(mem_timeout), 0);
    push(1, 1, 2, 1, 5, 1, 0, n);
    check("raw_prod_bubbles", n, 0);
    push(5, 1, 3, 1, 6, 1, 0, n);
    check("raw_bubbles", n, FWD ? 0 : 3);
    idle();
    #1;
    check("raw_fwd_a", 32'(fwd_a), FWD ? 2 : 0);
    check("raw_fwd_b", 32'(fwd_b), 0);
    drain();
    push(1, 1, 2, 1, 5, 1, 0, n);
    push(5, 1, 3, 1, 5, 1, 0, n);
    push(4, 1, 5, 1, 6, 1, 0, n);
    check("prio_bubbles", n, FWD ? 0 : 3);
    idle();
    #1;
    check("prio_fwd_a", 32'(fwd_a), 0);
    check("prio_fwd_b", 32'(fwd_b), FWD ? 2 : 0);
    drain();
    push(1, 1, 0, 0, 7, 1, 1, n);
    push(7, 1, 2, 1, 8, 1, 0, n);
    check("lu_bubbles", n, FWD ? 1 : 3);
    idle();
    #1;
    check("lu_fwd_a", 32'(fwd_a), FWD ? 1 : 0);
    drain();
    push(1, 1, 0, 0, 7, 1, 1, n);
    ins(7, 1, 2, 1, 8, 1, 0);
    ex_branch_taken = 1'b1;
    #1;
    check("br_lu_ctl", ctl(), FLUSH);
    tick();
    ex_branch_taken = 1'b0;
    idle();
    #1;
    check("br_after_ctl", ctl(), RUN);
    drain();
    push(1, 1, 0, 0, 7, 1, 1, n);
    ins(7, 1, 2, 1, 8, 1, 0);
    ex_branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    #1;
    check("brfrz_ctl0", ctl(), FROZEN);
    tick();
    check("brfrz_ctl1", ctl(), FROZEN);
    mem_ready = 1'b1;
    #1;
    check("brfrz_rel_ctl", ctl(), FLUSH);
    tick();
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    drain();
    push(1, 1, 0, 0, 0, 1, 0, n);
    check("x0_prod_bubbles", n, 0);
    push(0, 1, 0, 1, 9, 1, 0, n);
    check("x0_bubbles", n, 0);
    idle();
    #1;
    check("x0_fwd", 32'({fwd_a, fwd_b}), 0);
    drain();
    push(1, 1, 2, 1, 5, 1, 0, n);
    push(5, 1, 3, 1, 6, 1, 0, n);
    idle();
    mem_req = 1'b1;
    #1;
    check("frz_hold_fwd0", 32'(fwd_a), FWD ? 2 : 0);
    repeat (3) tick();
    check("frz_hold_fwd3", 32'(fwd_a), FWD ? 2 : 0);
    check("frz_hold_ctl", ctl(), FROZEN);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_req = 1'b0;
    #1;
    check("frz_rst_ctl", ctl(), RUN);
    check("frz_rst_fwd", 32'({fwd_a, fwd_b}), 0);
    check("frz_rst_timeout", 32'(mem_timeout), 0);
    tick();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("to_ctl", ctl(), FROZEN);
      check("to_flag", 32'(mem_timeout), 32'(i >= 15));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("to_rel_ctl", ctl(), RUN);
    check("to_rel_flag", 32'(mem_timeout), 1);
    tick();
    mem_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("to_sticky", 32'(mem_timeout), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("to_rst_clear", 32'(mem_timeout), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and pipeline-sequencing controller for the parametrised 5-stage (IF/ID/EX/MEM/WB) successor of the single-cycle RV32I core. Tracks the destination and source registers of in-flight instructions in shadow stage registers and produces the PC and pipeline-register enables, flushes, and ALU operand-forwarding selects. It also freezes the whole pipeline on a multi-cycle data-memory handshake.

## Interface
- REG_AW, 5, register-address width
- MEM_TIMEOUT, 15, freeze cycles before `mem_timeout` is raised (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_AW  ID source registers
- id_use_rs1, id_use_rs2  in  1  ID instruction reads that source
- id_rd  in  REG_AW  ID destination
- id_regwrite, id_memread  in  1  ID control bits from CU
- ex_branch_taken  in  1  EX branch resolved taken (CU branch & branching-unit select)
- mem_req, mem_ready  in  1  MEM-stage access request / data memory done
- pc_en, ifid_en  out  1  load PC / IF-ID register
- ifid_flush, idex_flush  out  1  clear IF-ID / insert bubble into ID-EX
- pipe_en  out  1  enable ID-EX, EX-MEM, MEM-WB registers
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
- mem_timeout  out  1  sticky freeze-timeout error

## Operation
- Shadow stages EX, MEM, WB each hold {valid, rd, rs1, rs2, regwrite, memread}. They advance on the clock edge when `pipe_en`=1. EX loads from ID inputs, or valid=0 when `idex_flush`. `regwrite` with rd==0 is treated as no write.
- Priority: freeze > flush > stall > run.
- Freeze: `mem_req & ~mem_ready`. All enables are 0, flushes are 0, and shadows hold. The freeze counter increments and saturates at MEM_TIMEOUT. At MEM_TIMEOUT, `mem_timeout` is set and stays set until reset. The counter clears on any non-freeze cycle.
- Flush (not frozen, `ex_branch_taken`): pc_en=1, ifid_flush=1, idex_flush=1, pipe_en=1. A simultaneous stall condition is ignored.
- Hazard match: a later stage has valid & regwrite & rd==id_rsN, with id_useN and id_valid asserted.
- Stall: pc_en=0, ifid_en=0, idex_flush=1, pipe_en=1.
- Forwarding (computed for the EX shadow rs1/rs2):
  - EX/MEM match selects 10, taking priority over MEM/WB match (01). Otherwise 00.
  - MEM-stage match is only forwarded when MEM is not a load. A load in MEM matching EX is illegal; the bench asserts it never happens.
- Run: pc_en=ifid_en=pipe_en=1, flushes 0.

## Timing
- Control outputs are combinational from the shadow registers, the counter, and the current inputs. State updates on the rising clk edge only.
- Reset values: shadows invalid, counter 0, mem_timeout 0. Outputs after reset: pc_en=ifid_en=pipe_en=1, flushes 0, fwd 00.
- Reset asserted mid-freeze or mid-stall clears everything on that edge; the pipeline runs the next cycle.
- Branch penalty: 2 killed instructions. A branch arriving during a freeze is held in EX and honoured on the first unfrozen cycle.
- Freeze of N cycles delays every stage by exactly N cycles. No shadow content is lost.

## Configuration
- `HAZARD_FWD_EN` defined:
  - Forwarding is active.
  - Stall only on load-use, i.e. a match against the EX shadow with memread=1. This costs exactly 1 bubble.
- `HAZARD_FWD_EN` undefined:
  - fwd_a/fwd_b are tied to 00.
  - Stall on any hazard match against EX, MEM or WB. The regfile has no write-through.
  - A RAW dependency on the immediately preceding ALU op costs 3 bubbles.

## Structure
- Package `riscv_pipe_pkg`:
  - `fwd_sel_e` (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10)
  - `stage_info_t` struct
  - default REG_AW localparam
- Counter width is $clog2(MEM_TIMEOUT+1).
- One sub-module, `fwd_select`: combinational per-operand forwarding mux-select generator, instantiated twice (A, B). It is compiled out under undefined `HAZARD_FWD_EN`.

## Test plan
- Back-to-back `add x5,x1,x2; sub x6,x5,x3`:
  - FWD_EN: no stall, fwd_a=10 in sub's EX cycle.
  - No FWD_EN: 3 cycles of pc_en=0.
- `lw x7,0(x1); add x8,x7,x2`, FWD_EN: exactly 1 cycle pc_en=0/idex_flush=1, then fwd_a=01.
- ex_branch_taken=1 in the same cycle as a load-use match: ifid_flush=idex_flush=1, pc_en=1, no stall.
- mem_req=1, mem_ready=0 for 20 cycles (MEM_TIMEOUT=15):
  - all enables 0
  - mem_timeout rises on cycle 15 and stays 1 after mem_ready
  - cleared only by reset
- Reset pulsed during a 5-cycle freeze: next cycle pc_en=1, fwd 00, mem_timeout=0.
- Writes to x0 (`addi x0,x1,1; add x9,x0,x0`): no stall, fwd 00.
